mod_counter: RTL and testbench



---
 rtl/mod_counter_pkg.sv | 14 +
 rtl/mod_counter_prescale.sv | 33 +++
 rtl/mod_counter.sv | 107 ++++++++++
 tb/tb_mod_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter and its prescaler.
package mod_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Prescaler register width; a single-cycle prescale still needs one bit.
   function automatic int unsigned presc_width(input int unsigned prescale);
      int unsigned w;
      w = $clog2(prescale);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Enable prescaler: issues one step every PRESCALE qualified enable cycles.
module mod_counter_prescale
   import mod_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic step
);

   localparam int unsigned   PW     = presc_width(PRESCALE);
   localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] DEC    = PW'(1);

   // Down-counter holding the number of enable cycles still needed before a step.
   logic [PW-1:0] remain_q;

   assign step = en && (remain_q == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         remain_q <= RELOAD;
      end else if (clr) begin
         remain_q <= RELOAD;
      end else if (en) begin
         remain_q <= (remain_q == '0) ? RELOAD : remain_q - DEC;
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaled enable, clear, clipped load and terminal-count pulse.
// Build option: MOD_COUNTER_SATURATE_EN makes a step at the bound hold D instead of wrapping.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned MODULUS  = 2**WIDTH,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] D,
   output logic             tc
);

   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_q;
   logic             tc_nxt;
   logic             step;
   logic             presc_clr;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   diff_dn;
   logic             wrap_up;
   logic             wrap_dn;
   logic             load_over;

   // Load or clear restarts the prescale window, so a concurrent step is lost.
   assign presc_clr = clr | load;

   mod_counter_prescale #(
      .PRESCALE (PRESCALE)
   ) u_prescale (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (presc_clr),
      .en      (en),
      .step    (step)
   );

   // One extra bit: carry out reaching MODULUS marks the top, borrow marks the bottom.
   assign sum_up    = {1'b0, count_q} + ONE_EXT;
   assign diff_dn   = {1'b0, count_q} - ONE_EXT;
   assign wrap_up   = (sum_up == MOD_EXT);
   assign wrap_dn   = diff_dn[WIDTH];
   assign load_over = ({1'b0, load_val} >= MOD_EXT);

   always_comb begin
      count_nxt = count_q;
      tc_nxt    = 1'b0;
      if (clr) begin
         count_nxt = '0;
      end else if (load) begin
         count_nxt = load_over ? MAX_VAL : load_val;
      end else if (step) begin
         case (up)
            DIR_UP: begin
               if (wrap_up) begin
                  tc_nxt = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
                  count_nxt = count_q;
`else
                  count_nxt = '0;
`endif
               end else begin
                  count_nxt = sum_up[WIDTH-1:0];
               end
            end
            DIR_DOWN: begin
               if (wrap_dn) begin
                  tc_nxt = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
                  count_nxt = count_q;
`else
                  count_nxt = MAX_VAL;
`endif
               end else begin
                  count_nxt = diff_dn[WIDTH-1:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_nxt;
         tc_q    <= tc_nxt;
      end
   end

   assign D  = count_q;
   assign tc = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: two instances (MODULUS=10, PRESCALE 1 and 3) against a behavioural model.
module tb_mod_counter;
   import mod_counter_pkg::*;

   localparam int W = 4;
   localparam int M = 10;
`ifdef MOD_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         clr = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic [W-1:0] d_a, d_b;
   logic         tc_a, tc_b;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) u_a (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .D(d_a), .tc(tc_a)
   );

   mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(3)) u_b (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .D(d_b), .tc(tc_b)
   );

   typedef struct {
      logic [W-1:0] d_a;
      logic         tc_a;
      logic [W-1:0] d_b;
      logic         tc_b;
   } exp_t;

   typedef struct {
      logic         clr;
      logic         load;
      logic [W-1:0] lv;
      logic         en;
      logic         up;
      logic [W-1:0] d;
      logic         tc;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[16];
   int   md[2];
   int   mp[2];
   int   mtc[2];
   int   pre[2];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         md[k] = 0;
         mp[k] = 0;
         mtc[k] = 0;
      end
   endtask

   task automatic model_edge(input logic c, input logic l, input logic [W-1:0] v,
                             input logic e, input logic u);
      for (int k = 0; k < 2; k++) begin
         mtc[k] = 0;
         if (c) begin
            md[k] = 0;
            mp[k] = 0;
         end else if (l) begin
            md[k] = (int'(v) >= M) ? M - 1 : int'(v);
            mp[k] = 0;
         end else if (e) begin
            if (mp[k] == pre[k] - 1) begin
               mp[k] = 0;
               if (u == DIR_UP) begin
                  if (md[k] == M - 1) begin
                     mtc[k] = 1;
                     if (!SAT) md[k] = 0;
                  end else begin
                     md[k] = md[k] + 1;
                  end
               end else begin
                  if (md[k] == 0) begin
                     mtc[k] = 1;
                     if (!SAT) md[k] = M - 1;
                  end else begin
                     md[k] = md[k] - 1;
                  end
               end
            end else begin
               mp[k] = mp[k] + 1;
            end
         end
      end
   endtask

   // Drive one clock of stimulus; expected result queued now, compared after the edge.
   task automatic cycle(input logic c, input logic l, input logic [W-1:0] v,
                        input logic e, input logic u,
                        input bit use_tab, input logic [W-1:0] td, input logic ttc);
      exp_t x;
      exp_t got;
      clr = c;
      load = l;
      load_val = v;
      en = e;
      up = u;
      model_edge(c, l, v, e, u);
      x.d_a  = use_tab ? td : W'(md[0]);
      x.tc_a = use_tab ? ttc : mtc[0][0];
      x.d_b  = W'(md[1]);
      x.tc_b = mtc[1][0];
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         got = sb.pop_front();
         check("d_a", int'(d_a), int'(got.d_a));
         check("tc_a", int'(tc_a), int'(got.tc_a));
         check("d_b", int'(d_b), int'(got.d_b));
         check("tc_b", int'(tc_b), int'(got.tc_b));
      end
   endtask

   task automatic step_only(input logic c, input logic l, input logic [W-1:0] v,
                            input logic e, input logic u);
      cycle(c, l, v, e, u, 1'b0, '0, 1'b0);
   endtask

   initial begin
      int first_tc;
      int second_tc;

      pre[0] = 1;
      pre[1] = 3;
      model_reset();

      vecs[0]  = '{1'b0, 1'b1, 4'd12, 1'b0, DIR_UP,   4'd9, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 4'd0,  1'b1, DIR_UP,   SAT ? 4'd9 : 4'd0, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 4'd1,  1'b0, DIR_UP,   4'd1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, DIR_UP,   4'd2, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b0, DIR_UP,   4'd2, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'd7,  1'b0, DIR_UP,   4'd7, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, DIR_DOWN, 4'd6, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 4'd5,  1'b0, DIR_UP,   4'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b1, DIR_DOWN, SAT ? 4'd0 : 4'd9, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 4'd3,  1'b1, DIR_UP,   4'd3, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 4'd10, 1'b0, DIR_UP,   4'd9, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 4'd0,  1'b1, DIR_UP,   4'd0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 4'd15, 1'b0, DIR_UP,   4'd9, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 4'd0,  1'b1, DIR_DOWN, 4'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b1, DIR_DOWN, SAT ? 4'd0 : 4'd9, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b1, DIR_DOWN, SAT ? 4'd0 : 4'd8, SAT ? 1'b1 : 1'b0};

      // Reset state.
      #1 reset_n = 1'b0;
      #10;
      check("reset_d_a", int'(d_a), 0);
      check("reset_tc_a", int'(tc_a), 0);
      check("reset_d_b", int'(d_b), 0);
      check("reset_tc_b", int'(tc_b), 0);
      #2 reset_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up,
               1'b1, vecs[i].d, vecs[i].tc);
      end

      // Free count up from zero: ten-cycle wrap period.
      step_only(1'b1, 1'b0, '0, 1'b0, DIR_UP);
      first_tc = -1;
      second_tc = -1;
      for (int i = 1; i <= 24; i++) begin
         step_only(1'b0, 1'b0, '0, 1'b1, DIR_UP);
         if (tc_a) begin
            if (first_tc < 0) first_tc = i;
            else if (second_tc < 0) second_tc = i;
         end
      end
      check("tc_first_step", first_tc, 10);
      check("tc_period", second_tc - first_tc, SAT ? 1 : 10);

      // Count down from zero.
      step_only(1'b1, 1'b0, '0, 1'b0, DIR_UP);
      for (int i = 0; i < 6; i++) step_only(1'b0, 1'b0, '0, 1'b1, DIR_DOWN);

      // Prescale of 3 with gaps in enable.
      step_only(1'b1, 1'b0, '0, 1'b0, DIR_UP);
      step_only(1'b0, 1'b0, '0, 1'b1, DIR_UP);
      step_only(1'b0, 1'b0, '0, 1'b0, DIR_UP);
      step_only(1'b0, 1'b0, '0, 1'b1, DIR_UP);
      check("presc_hold_b", int'(d_b), 0);
      step_only(1'b0, 1'b0, '0, 1'b1, DIR_UP);
      check("presc_step_b", int'(d_b), 1);
      check("presc_step_a", int'(d_a), 3);

      // Async reset between edges at D=7.
      step_only(1'b0, 1'b1, 4'd7, 1'b0, DIR_UP);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_d_a", int'(d_a), 0);
      check("async_rst_tc_a", int'(tc_a), 0);
      check("async_rst_d_b", int'(d_b), 0);
      model_reset();
      load = 1'b0;
      en = 1'b1;
      @(posedge clk);
      #1;
      check("rst_held_d_a", int'(d_a), 0);
      #3 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step_only(1'b0, 1'b0, '0, 1'b1, DIR_UP);
      check("post_rst_d_b", int'(d_b), 1);

      // Randomised mix against the model.
      for (int i = 0; i < 300; i++) begin
         step_only(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                   W'($urandom_range(0, 15)),
                   ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 3) != 0) ? DIR_UP : DIR_DOWN);
      end

      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
